// File: rtl/sqrt_unit.sv
// -----------------------------------------------------------------------------
// sqrt_unit
//   Iterative integer square root. One shift/subtract digit step per clock
//   produces floor(sqrt(xin)) and the remainder xin - root^2 after XW/2
//   iterations, with an optional round-to-nearest adjustment of the root.
//
// Ports
//   clock  in   rising-edge master clock
//   reset  in   asynchronous reset, active low
//   start  in   request a new root (sampled only while busy = 0)
//   abort  in   synchronous cancel of a running operation
//   round  in   0 = floor, 1 = round-to-nearest (captured with start)
//   xin    in   XW-bit unsigned argument (captured with start)
//   busy   out  operation in progress
//   done   out  one-cycle strobe, sqrt/rem have just updated
//   sqrt   out  N-bit root register
//   rem    out  N+1-bit remainder register, always xin - floor(sqrt)^2
//
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module sqrt_unit #(
  parameter int XW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            round,
  input  logic [XW-1:0]   xin,
  output logic            busy,
  output logic            done,
  output logic [XW/2-1:0] sqrt,
  output logic [XW/2:0]   rem
);

  localparam int N  = XW / 2;
  localparam int CW = $clog2(N) + 1;

  generate
    if ((XW % 2) != 0 || XW < 4) begin : g_xw_check
      $error("sqrt_unit: XW must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   xs_q, xs_d;
  logic [N+1:0]    r_q, r_d;
  logic [N-1:0]    q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rmode_q, rmode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    sqrt_q, sqrt_d;
  logic [N:0]      rem_q, rem_d;

  // One digit step: bring down the next two argument bits and try to
  // subtract 4*q+1. The extra top bit of w_sub is the borrow.
  logic [N+1:0]    w_t;
  logic [N+2:0]    w_sub;
  logic            w_neg;
  logic            w_up;
  logic [N-1:0]    w_root;

  assign w_t   = {r_q[N-1:0], xs_q[XW-1:XW-2]};
  assign w_sub = {1'b0, w_t} - {1'b0, q_q, 2'b01};
  assign w_neg = w_sub[N+2];

  // x - q^2 > q means x is past the midpoint (q+0.5)^2, so the nearest
  // root is q+1; an all-ones root cannot be incremented and saturates.
  assign w_up   = rmode_q && (r_q > {2'b00, q_q});
  assign w_root = (w_up && !(&q_q)) ? (q_q + {{(N-1){1'b0}}, 1'b1}) : q_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      rmode_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sqrt_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rmode_q <= rmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sqrt_q  <= sqrt_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    rmode_d = rmode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sqrt_d  = sqrt_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xs_d    = xin;
          rmode_d = round;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          r_d   = w_neg ? w_t : w_sub[N+1:0];
          q_d   = {q_q[N-2:0], ~w_neg};
          xs_d  = {xs_q[XW-3:0], 2'b00};
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(N-1)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!abort) begin
          rem_d  = r_q[N:0];
          sqrt_d = w_root;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sqrt = sqrt_q;
  assign rem  = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_unit.sv
// -----------------------------------------------------------------------------
// tb_sqrt_unit
//   Self-checking bench for sqrt_unit: a 32-bit instance driven from a
//   directed vector table plus handshake/abort/reset sequences, and an 8-bit
//   instance swept exhaustively against a search-based reference root.
//
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start32, abort32, round32;
  logic [31:0] xin32;
  logic        busy32, done32;
  logic [15:0] sqrt32;
  logic [16:0] rem32;

  // 8-bit instance
  logic        start8, abort8, round8;
  logic [7:0]  xin8;
  logic        busy8, done8;
  logic [3:0]  sqrt8;
  logic [4:0]  rem8;

  sqrt_unit #(.XW(32)) u_dut32 (
    .clock(clk), .reset(rst_n), .start(start32), .abort(abort32),
    .round(round32), .xin(xin32), .busy(busy32), .done(done32),
    .sqrt(sqrt32), .rem(rem32)
  );

  sqrt_unit #(.XW(8)) u_dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .abort(abort8),
    .round(round8), .xin(xin8), .busy(busy8), .done(done8),
    .sqrt(sqrt8), .rem(rem8)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] x;
    logic        rnd;
    int          es;
    int          er;
  } vec_t;

  vec_t vecs[6];

  // Start one operation on the 32-bit unit and wait (bounded) for done.
  task automatic op32(input logic [31:0] x, input logic rnd,
                      output int lat, output int bcyc);
    @(negedge clk);
    start32 = 1'b1; xin32 = x; round32 = rnd;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0; bcyc = 0;
    while (!done32 && lat < 40) begin
      if (busy32) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic rnd, output int lat);
    @(negedge clk);
    start8 = 1'b1; xin8 = x; round8 = rnd;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcyc, s, r, es;
    logic saw_done;

    vecs[0] = '{32'd0,          1'b0, 0,     0};
    vecs[1] = '{32'd1000000,    1'b0, 1000,  0};
    vecs[2] = '{32'hFFFF_FFFF,  1'b0, 65535, 131070};
    vecs[3] = '{32'd1001001,    1'b1, 1001,  1001};
    vecs[4] = '{32'd1001000,    1'b1, 1000,  1000};
    vecs[5] = '{32'hFFFF_FFFF,  1'b1, 65535, 131070};

    rst_n = 1'b0;
    start32 = 1'b0; abort32 = 1'b0; round32 = 1'b0; xin32 = '0;
    start8  = 1'b0; abort8  = 1'b0; round8  = 1'b0; xin8  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",  busy32, 0);
    check("reset done",  done32, 0);
    check("reset sqrt",  sqrt32, 0);
    check("reset rem",   rem32,  0);
    check("reset sqrt8", sqrt8,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      op32(vecs[i].x, vecs[i].rnd, lat, bcyc);
      check($sformatf("vec%0d sqrt", i), sqrt32, vecs[i].es);
      check($sformatf("vec%0d rem", i),  rem32,  vecs[i].er);
      check($sformatf("vec%0d latency", i), lat, 17);
      check($sformatf("vec%0d busy cycles", i), bcyc, 17);
    end

    // start during a run is ignored
    @(negedge clk);
    start32 = 1'b1; xin32 = 32'd1000000; round32 = 1'b0;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 40) begin
      if (lat == 5) begin start32 = 1'b1; xin32 = 32'd144; round32 = 1'b1; end
      else          begin start32 = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    start32 = 1'b0;
    check("ignored start sqrt", sqrt32, 1000);
    check("ignored start rem",  rem32,  0);
    check("ignored start latency", lat, 17);
    @(posedge clk); #1;
    check("ignored start not queued", busy32, 0);

    // back-to-back: start accepted in the done cycle
    op32(32'd1001001, 1'b1, lat, bcyc);
    check("b2b first sqrt", sqrt32, 1001);
    check("b2b first rem",  rem32,  1001);
    start32 = 1'b1; xin32 = 32'd144; round32 = 1'b0;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("b2b accepted busy", busy32, 1);
    lat = 0;
    while (!done32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b second sqrt", sqrt32, 12);
    check("b2b second rem",  rem32,  0);
    check("b2b second latency", lat, 17);

    // abort mid-run
    @(negedge clk);
    start32 = 1'b1; xin32 = 32'hFFFF_FFFF; round32 = 1'b0;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    check("abort busy falls", busy32, 0);
    saw_done = done32;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done32) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 0);
    check("abort sqrt held", sqrt32, 12);
    check("abort rem held",  rem32,  0);
    op32(32'd1000000, 1'b0, lat, bcyc);
    check("post-abort sqrt", sqrt32, 1000);
    check("post-abort rem",  rem32,  0);
    check("post-abort latency", lat, 17);

    // asynchronous reset mid-run
    @(negedge clk);
    start32 = 1'b1; xin32 = 32'hFFFF_FFFF; round32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy32, 0);
    check("async reset done", done32, 0);
    check("async reset sqrt", sqrt32, 0);
    check("async reset rem",  rem32,  0);
    @(negedge clk);
    rst_n = 1'b1;
    op32(32'd144, 1'b0, lat, bcyc);
    check("post-reset sqrt", sqrt32, 12);
    check("post-reset rem",  rem32,  0);
    check("post-reset latency", lat, 17);

    // 8-bit spot checks
    op8(8'd200, 1'b0, lat);
    check("x8 200 sqrt", sqrt8, 14);
    check("x8 200 rem",  rem8,  4);
    check("x8 latency",  lat,   5);
    op8(8'd255, 1'b1, lat);
    check("x8 255 round sqrt", sqrt8, 15);
    check("x8 255 round rem",  rem8,  30);

    // 8-bit exhaustive sweep against a search-based reference
    for (int rm = 0; rm < 2; rm++) begin
      for (int x = 0; x < 256; x++) begin
        s = 0;
        while ((s + 1) * (s + 1) <= x) s++;
        r  = x - s * s;
        es = (rm == 1 && r > s) ? ((s + 1 > 15) ? 15 : s + 1) : s;
        op8(x[7:0], rm[0], lat);
        check($sformatf("x8 sweep x=%0d rnd=%0d sqrt", x, rm), sqrt8, es);
        check($sformatf("x8 sweep x=%0d rnd=%0d rem", x, rm),  rem8,  r);
        check($sformatf("x8 sweep x=%0d rnd=%0d latency", x, rm), lat, 5);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
